// File: rtl/led_timer_periph_pkg.sv
// rtl/led_timer_periph_pkg.sv - shared constants, types and helpers for the LED/timer peripheral
package led_timer_pkg;

    localparam logic [2:0] OFF_LED     = 3'd0;
    localparam logic [2:0] OFF_TIMER   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_CTRL    = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } bus_state_t;

    // Replace only the bytes whose strobe is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                result[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/led_timer_periph_if.sv
// rtl/led_timer_periph_if.sv - PicoRV32 native memory bus bundle
interface led_timer_periph_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/led_timer_periph_interval_timer.sv
// rtl/led_timer_periph_interval_timer.sv - free-running counter with compare reload and load port
module interval_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [31:0] i_load_value,
    input  logic [31:0] i_compare,
    output logic [31:0] o_count,
    output logic        o_hit
);

    logic [31:0] r_count;
    logic        w_equal;

    assign w_equal = (r_count == i_compare);
    // A bus load pre-empts the reload, so no hit is reported in that cycle
    assign o_hit   = i_en & ~i_load & w_equal;
    assign o_count = r_count;

    // Counter: load beats reload, reload beats increment, hold when disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (o_hit) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/led_timer_periph.sv
// rtl/led_timer_periph.sv - memory-mapped LED and interval timer with match interrupt
module led_timer_periph
    import led_timer_pkg::*;
#(
    parameter logic [3:0]  SEL_NIBBLE    = 4'h2,
    parameter logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    led_timer_periph_if.slave   bus,
    output logic                led,
    output logic                irq
);

    bus_state_t  r_state;
    bus_state_t  w_state_next;
    logic [31:0] r_rdata;
    logic [31:0] r_compare;
    logic [2:0]  r_ctrl;
    logic        r_match;
    logic        r_led;

    logic        w_sel;
    logic        w_accept;
    logic        w_write;
    logic [2:0]  w_off;
    logic        w_wr_led;
    logic        w_wr_timer;
    logic        w_wr_compare;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic [31:0] w_count;
    logic        w_hit;
    logic [31:0] w_rd_val;

    assign w_sel        = (bus.mem_addr[31:28] == SEL_NIBBLE);
    // Being in IDLE guarantees mem_ready is low, so a lingering request is not re-acknowledged
    assign w_accept     = (r_state == IDLE) & bus.mem_valid & w_sel;
    assign w_write      = w_accept & (|bus.mem_wstrb);
    assign w_off        = bus.mem_addr[4:2];
    assign w_wr_led     = w_write & (w_off == OFF_LED)     & bus.mem_wstrb[0];
    assign w_wr_timer   = w_write & (w_off == OFF_TIMER);
    assign w_wr_compare = w_write & (w_off == OFF_COMPARE);
    assign w_wr_ctrl    = w_write & (w_off == OFF_CTRL)    & bus.mem_wstrb[0];
    assign w_wr_status  = w_write & (w_off == OFF_STATUS)  & bus.mem_wstrb[0];

    interval_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_en         (r_ctrl[CTRL_EN]),
        .i_load       (w_wr_timer),
        .i_load_value (merge_bytes(w_count, bus.mem_wdata, bus.mem_wstrb)),
        .i_compare    (r_compare),
        .o_count      (w_count),
        .o_hit        (w_hit)
    );

    // Bus FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus FSM next state: accept goes to ACK, ACK always returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = ACK;
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bus FSM outputs: ready and data only while acknowledging, zero otherwise for OR-combining
    always_comb begin
        bus.mem_ready = (r_state == ACK);
        bus.mem_rdata = (r_state == ACK) ? r_rdata : 32'd0;
    end

    // Read mux; unmapped offsets return zero
    always_comb begin
        w_rd_val = 32'd0;
        case (w_off)
            OFF_LED:     w_rd_val = {31'd0, r_led};
            OFF_TIMER:   w_rd_val = w_count;
            OFF_COMPARE: w_rd_val = r_compare;
            OFF_CTRL:    w_rd_val = {29'd0, r_ctrl};
            OFF_STATUS:  w_rd_val = {31'd0, r_match};
            default:     w_rd_val = 32'd0;
        endcase
    end

    // Read data captured on accept, cleared on the following edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_accept) begin
            r_rdata <= w_rd_val;
        end else begin
            r_rdata <= '0;
        end
    end

    // COMPARE and CTRL registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_compare <= COMPARE_RESET;
            r_ctrl    <= '0;
        end else begin
            if (w_wr_compare) r_compare <= merge_bytes(r_compare, bus.mem_wdata, bus.mem_wstrb);
            if (w_wr_ctrl)    r_ctrl    <= bus.mem_wdata[2:0];
        end
    end

    // Sticky match flag: a hit in the same cycle as a W1C keeps it set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit | (r_match & ~(w_wr_status & bus.mem_wdata[0]));
        end
    end

    // LED: firmware write wins over an auto-toggle in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= 1'b0;
        end else if (w_wr_led) begin
            r_led <= bus.mem_wdata[0];
        end else if (w_hit & r_ctrl[CTRL_AUTO]) begin
            r_led <= ~r_led;
        end
    end

    assign led = r_led;
    assign irq = r_match & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_led_timer_periph.sv
// tb/tb_led_timer_periph.sv - self-checking bench for led_timer_periph
module tb_led_timer_periph;

    localparam logic [31:0] BASE      = 32'h2000_0000;
    localparam logic [31:0] A_LED     = BASE + 32'h00;
    localparam logic [31:0] A_TIMER   = BASE + 32'h04;
    localparam logic [31:0] A_COMPARE = BASE + 32'h08;
    localparam logic [31:0] A_CTRL    = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS  = BASE + 32'h10;
    localparam logic [31:0] A_UNUSED  = BASE + 32'h14;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic led;
    logic irq;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [31:0] exp_q[$];

    led_timer_periph_if bus();

    led_timer_periph #(.SEL_NIBBLE(4'h2), .COMPARE_RESET(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .led   (led),
        .irq   (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] rdata, output int lat, output int rcyc);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        lat = 0;
        rdata = 32'd0;
        rcyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mem_ready) begin
                rdata = bus.mem_rdata;
                rcyc = cyc;
                break;
            end
        end
        if (!bus.mem_ready) begin
            total++;
            bad++;
            $display("FAIL bus_timeout addr=%h got_ready=0 want_ready=1", addr);
        end
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        int lat, rc;
        bus_xfer(addr, wdata, 4'hF, rd, lat, rc);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat, rc;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({led, irq, bus.mem_ready, bus.mem_rdata} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {led, irq, bus.mem_ready, bus.mem_rdata});
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        bus_xfer(A_COMPARE, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL reset_compare got=%h want=ffffffff", rd);
        end
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL reset_latency got=%0d want=1", lat);
        end
    endtask

    task automatic test_led_rw();
        logic [31:0] rd;
        int lat, rc, pulses;
        wr(A_LED, 32'hFFFF_FFFF);
        total++;
        if (led !== 1'b1) begin
            bad++;
            $display("FAIL led_pin got=%b want=1", led);
        end
        exp_q.push_back(32'h1);
        bus_xfer(A_LED, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL led_read got=%h want=1", rd);
        end
        // request held for two cycles must produce one ready pulse
        pulses = 0;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = A_LED;
        bus.mem_wstrb = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) pulses++;
            if (i == 1) begin
                @(negedge clk);
                bus.mem_valid = 1'b0;
            end
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL held_valid_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_unselected();
        logic [31:0] rd;
        int lat, rc, pulses;
        logic rd_nonzero;
        pulses = 0;
        rd_nonzero = 1'b0;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h3000_0000;
        bus.mem_wstrb = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) pulses++;
            if (bus.mem_rdata !== 32'd0) rd_nonzero = 1'b1;
        end
        @(negedge clk);
        bus.mem_valid = 1'b0;
        total++;
        if (pulses !== 0 || rd_nonzero !== 1'b0) begin
            bad++;
            $display("FAIL unselected got_pulses=%0d got_rd_nonzero=%b want=0,0", pulses, rd_nonzero);
        end
        wr(A_UNUSED, 32'hDEAD_BEEF);
        exp_q.push_back(32'd0);
        bus_xfer(A_UNUSED, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front() || lat !== 1) begin
            bad++;
            $display("FAIL unused_offset got=%h lat=%0d want=0 lat=1", rd, lat);
        end
    endtask

    task automatic test_auto_toggle();
        logic [31:0] rd, exp;
        int lat, rc, c0, bad_led;
        wr(A_TIMER, 32'd0);
        wr(A_COMPARE, 32'd4);
        wr(A_STATUS, 32'd1);
        wr(A_LED, 32'd0);
        bus_xfer(A_CTRL, 32'h3, 4'hF, rd, lat, c0);
        bad_led = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (led !== 1'(((k / 5) % 2))) bad_led++;
        end
        total++;
        if (bad_led !== 0) begin
            bad++;
            $display("FAIL auto_toggle_led got_wrong_cycles=%0d want=0", bad_led);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_masked got=%b want=0", irq);
        end
        for (int n = 0; n < 6; n++) begin
            bus_xfer(A_TIMER, 32'd0, 4'd0, rd, lat, rc);
            exp = 32'((rc - c0 - 1) % 5);
            exp_q.push_back(exp);
            total++;
            if (rd !== exp_q.pop_front()) begin
                bad++;
                $display("FAIL timer_read%0d got=%h want=%h", n, rd, exp);
            end
        end
        exp_q.push_back(32'h1);
        bus_xfer(A_STATUS, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL status_match got=%h want=1", rd);
        end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_irq_w1c();
        logic [31:0] rd;
        int lat, rc, c0, bad_irq;
        wr(A_TIMER, 32'd0);
        wr(A_COMPARE, 32'd9);
        wr(A_STATUS, 32'd1);
        bus_xfer(A_CTRL, 32'h7, 4'hF, rd, lat, c0);
        bad_irq = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (irq !== (k >= 10)) bad_irq++;
        end
        total++;
        if (bad_irq !== 0) begin
            bad++;
            $display("FAIL irq_rise got_wrong_cycles=%0d want=0", bad_irq);
        end
        for (int k = 11; k <= 19; k++) begin
            @(posedge clk);
            #1;
        end
        // W1C accepted on the same edge as the second match
        wr(A_STATUS, 32'd1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_vs_match_irq got=%b want=1", irq);
        end
        exp_q.push_back(32'h1);
        bus_xfer(A_STATUS, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL w1c_vs_match_status got=%h want=1", rd);
        end
        wr(A_STATUS, 32'd1);
        exp_q.push_back(32'h0);
        bus_xfer(A_STATUS, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front() || irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_clear got=%h irq=%b want=0 irq=0", rd, irq);
        end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        int lat, rc;
        wr(A_TIMER, 32'h1234_5678);
        bus_xfer(A_TIMER, 32'h0000_AB00, 4'b0010, rd, lat, rc);
        exp_q.push_back(32'h1234_AB78);
        bus_xfer(A_TIMER, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL timer_byte got=%h want=1234ab78", rd);
        end
        wr(A_CTRL, 32'hFFFF_FFF8);
        exp_q.push_back(32'h0);
        bus_xfer(A_CTRL, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL ctrl_mask got=%h want=0", rd);
        end
    endtask

    task automatic test_compare_zero();
        logic [31:0] rd;
        int lat, c0, bad_led;
        wr(A_TIMER, 32'd0);
        wr(A_COMPARE, 32'd0);
        wr(A_LED, 32'd0);
        bus_xfer(A_CTRL, 32'h3, 4'hF, rd, lat, c0);
        bad_led = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (led !== 1'(k % 2)) bad_led++;
        end
        total++;
        if (bad_led !== 0) begin
            bad++;
            $display("FAIL compare_zero_toggle got_wrong_cycles=%0d want=0", bad_led);
        end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_reset_mid_ack();
        logic [31:0] rd;
        int lat, rc;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = A_COMPARE;
        bus.mem_wdata = 32'd7;
        bus.mem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        total++;
        if (bus.mem_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_ack_ready got=%b want=1", bus.mem_ready);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.mem_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_drops_ready got=%b want=0", bus.mem_ready);
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        bus_xfer(A_COMPARE, 32'd0, 4'd0, rd, lat, rc);
        total++;
        if (rd !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL compare_after_reset got=%h want=ffffffff", rd);
        end
    endtask

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wstrb = 4'd0;
        test_reset();
        test_led_rw();
        test_unselected();
        test_auto_toggle();
        test_irq_w1c();
        test_byte_write();
        test_compare_zero();
        test_reset_mid_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_timer_periph.md
# led_timer_periph

Memory-mapped LED and interval-timer peripheral on the PicoRV32 native memory bus, directly downstream of the CPU inside `main`. Firmware writes to it to drive `led`. It provides a programmable periodic match that can toggle the LED autonomously and raise an interrupt. It replaces software delay loops in the blink firmware.

## Interface

- `SEL_NIBBLE`, default 4'h2: peripheral is selected when `mem_addr[31:28] == SEL_NIBBLE`.
- `COMPARE_RESET`, default 32'hFFFF_FFFF: reset value of COMPARE.

- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `mem_valid` in 1: CPU request valid.
- `mem_addr` in 32: byte address; offset is `mem_addr[4:2]`.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte enables; 0 means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data, valid while `mem_ready` is high.
- `led` out 1: LED drive.
- `irq` out 1: level interrupt, equal to `STATUS.match & CTRL.irq_en`.

## Operation

Register map (word offsets):
- 0x00 LED: bit0 R/W. Other bits read 0.
- 0x04 TIMER: 32-bit counter. Read returns the live value; a write loads it.
- 0x08 COMPARE: R/W.
- 0x0C CTRL: bit0 `en`, bit1 `auto_toggle`, bit2 `irq_en`. Other bits read 0.
- 0x10 STATUS: bit0 `match`, sticky. Writing 1 clears it; writing 0 has no effect.
- Offsets 0x14 to 0x1C: reads return 0; writes are ignored but still acknowledged.

Write byte strobes:
- Honoured per byte on TIMER and COMPARE.
- For LED, CTRL and STATUS, only `wstrb[0]` matters.

Timer behaviour with `en=1`:
- If `TIMER == COMPARE`, the next cycle sets TIMER to 0 and sets `match`. If `auto_toggle` is set, `led` also inverts in that cycle.
- Otherwise TIMER increments by 1 and wraps modulo 2^32.
- The match period is therefore COMPARE+1 cycles.
- With `en=0`, TIMER holds its value.

Simultaneous events:
- A bus write to TIMER beats increment or match reload. No `match` is set by a match in that same cycle.
- A W1C on STATUS and a match in the same cycle: set wins, so `match` stays 1.
- A bus write to LED and an auto-toggle in the same cycle: the bus write wins.
- A write to COMPARE takes effect for the comparison on the following cycle.

Bus handshake:
- Two-state FSM: IDLE and ACK.
- IDLE → ACK when `mem_valid` is high, the peripheral is selected, and `mem_ready` is low. Register writes commit on this same edge. `mem_ready` goes to 1 and `mem_rdata` is loaded.
- ACK → IDLE unconditionally on the next edge. `mem_ready` returns to 0 and `mem_rdata` to 0.
- A request still present in ACK is not re-acknowledged. The CPU drops `mem_valid` after seeing ready.
- When unselected, `mem_ready` stays 0 and `mem_rdata` stays 0. This allows OR-combining rdata with other slaves.

## Timing

- Reset values: `led`=0, TIMER=0, COMPARE=`COMPARE_RESET`, CTRL=0, STATUS=0, `mem_ready`=0, `mem_rdata`=0, `irq`=0, FSM=IDLE.
- Reset asserted mid-transaction: `mem_ready` drops immediately, and the pending write is lost.
- Access latency: `mem_ready` is high on the first edge after `mem_valid` arrives, i.e. 1 cycle. A back-to-back access every 2 cycles is sustained.
- A TIMER read returns the value present in the cycle before `mem_ready`.
- `irq` is combinational from registered flags; it has no extra latency beyond `match`.
- COMPARE=0 with `en=1`: `match` is set every cycle, and `led` toggles every cycle when `auto_toggle` is set.

## Structure

- Package `led_timer_pkg` contains:
  - register offset constants (`OFF_LED`, `OFF_TIMER`, `OFF_COMPARE`, `OFF_CTRL`, `OFF_STATUS`);
  - CTRL bit indices;
  - the FSM state enum (IDLE, ACK);
  - a byte-merge function (old, wdata, wstrb) → new.
- One sub-module, `interval_timer`. It holds the counter, comparator, load port and match pulse output. The top level keeps the bus FSM, LED, CTRL and STATUS registers.

## Test plan

- Reset: hold `reset` for 3 cycles → all outputs 0. Read COMPARE → 0xFFFF_FFFF, with `mem_ready` high exactly 1 cycle after `mem_valid`.
- Write LED=1, then read it back → `led`=1 and rdata=0x1. Hold `mem_valid` for 2 cycles → exactly one `mem_ready` pulse.
- COMPARE=4, CTRL=0x3 → `match` set and `led` toggling every 5 cycles; TIMER reads cycle through 0 to 4.
- CTRL=0x7 with COMPARE=9 → `irq` rises 10 cycles after enable. A W1C on STATUS in the same cycle as the next match → `match` stays 1.
- Byte write to TIMER with `wstrb`=4'b0010 and data 0x0000_AB00, while TIMER=0x1234_5678 and disabled → TIMER reads 0x1234_AB78.
- Assert `reset` during an ACK cycle after a write to COMPARE=7 → `mem_ready` drops immediately and COMPARE=0xFFFF_FFFF.
